// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte register-access I2C master, 7-bit addressing.
//   Write: START, addr+W, reg_addr, data_wr, STOP.
//   Read:  START, addr+W, reg_addr, repeated START, addr+R, one byte, master NACK, STOP.
// Each bus bit is four quarters of CLK_DIV clk cycles. SCL and the SDA pull-down are
// registered so the bus pins never glitch.
//
// Optional feature: define I2C_MASTER_NACK_ABORT_EN to end a transaction with STOP right
// after the first ACK slot that sees a NACK. Default build runs the full sequence.
//
// Ports:
//   clk        in     system clock, rising edge
//   rst        in     synchronous active-high reset
//   enable     in     start request, sampled only while idle
//   rw         in     0 = register write, 1 = register read
//   slave_addr in  7  target device address
//   reg_addr   in  8  register address byte
//   data_wr    in  8  write data byte
//   data_rd    out 8  last byte read from the device
//   busy       out    transaction in progress
//   ack_error  out    slave NACK seen during the last transaction
//   sda        inout  open-drain data line (drives 0 or releases)
//   scl        out    push-pull clock line, idle high
module i2c_master_ctrl #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       ack_error,
  inout  wire        sda,
  output logic       scl
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    StIdle, StStart, StAddrW, StAck1, StReg, StAck2, StWdata, StAck3,
    StRstart, StAddrR, StAck4, StRdata, StMnack, StStop
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      data_rd_q, data_rd_d;
  logic            ack_err_q, ack_err_d;
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;
  logic [7:0]      tx_d;
  logic            tick, bit_end, sda_in, is_ack, scl_mid;

  assign sda_in  = sda;
  assign tick    = (div_q == DivW'(CLK_DIV - 1));
  assign bit_end = tick && (qtr_q == 2'd3);
  assign is_ack  = state_q inside {StAck1, StAck2, StAck3, StAck4};

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    data_rd_d = data_rd_q;
    ack_err_d = ack_err_q;

    if (state_q == StIdle) begin
      div_d = '0;
      qtr_d = '0;
      bit_d = '0;
      if (enable) begin
        rw_d      = rw;
        addr_d    = slave_addr;
        reg_d     = reg_addr;
        wdata_d   = data_wr;
        ack_err_d = 1'b0;
        state_d   = StStart;
      end
    end else begin
      if (tick) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + 1'b1;
      end

      // SDA is sampled at the end of the second high quarter.
      if (tick && (qtr_q == 2'd2)) begin
        if (is_ack && sda_in) ack_err_d = 1'b1;
        if (state_q == StRdata) rx_d = {rx_q[6:0], sda_in};
      end

      if (bit_end) begin
        bit_d = '0;
        case (state_q)
          StStart:  state_d = StAddrW;
          StAddrW: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAck1;
          end
          StAck1:   state_d = StReg;
          StReg: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAck2;
          end
          StAck2:   state_d = rw_q ? StRstart : StWdata;
          StWdata: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAck3;
          end
          StAck3:   state_d = StStop;
          StRstart: state_d = StAddrR;
          StAddrR: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = StAck4;
          end
          StAck4:   state_d = StRdata;
          StRdata: begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              data_rd_d = rx_q;
              state_d   = StMnack;
            end
          end
          StMnack:  state_d = StStop;
          StStop:   state_d = StIdle;
          default:  state_d = StIdle;
        endcase
`ifdef I2C_MASTER_NACK_ABORT_EN
        // ack_err_q is cleared on accept and any earlier NACK already aborted, so a set
        // flag here means this slot was NACKed.
        if (is_ack && ack_err_q) state_d = StStop;
`endif
      end
    end
  end

  // Bus levels are decoded from the next state so they line up with the state register.
  always_comb begin
    case (state_d)
      StAddrW: tx_d = {addr_d, 1'b0};
      StReg:   tx_d = reg_d;
      StWdata: tx_d = wdata_d;
      StAddrR: tx_d = {addr_d, 1'b1};
      default: tx_d = 8'hFF;
    endcase

    scl_mid   = qtr_d[1] ^ qtr_d[0];
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      StIdle: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
      StStart: begin
        scl_d     = (qtr_d != 2'd3);
        sda_low_d = (qtr_d != 2'd0);
      end
      StRstart: begin
        scl_d     = scl_mid;
        sda_low_d = qtr_d[1];
      end
      StStop: begin
        scl_d     = (qtr_d != 2'd0);
        sda_low_d = ~qtr_d[1];
      end
      StAddrW, StReg, StWdata, StAddrR: begin
        scl_d     = scl_mid;
        sda_low_d = ~tx_d[3'd7 - bit_d];
      end
      default: begin
        // ACK slots, read data and master NACK: SDA released.
        scl_d     = scl_mid;
        sda_low_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      reg_q     <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      data_rd_q <= '0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      data_rd_q <= data_rd_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  assign sda       = sda_low_q ? 1'b0 : 1'bz;
  assign scl       = scl_q;
  assign busy      = (state_q != StIdle);
  assign ack_error = ack_err_q;
  assign data_rd   = data_rd_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural register slave at 0x68.
module tb_i2c_master_ctrl;

  localparam int unsigned ClkDiv = 2;
  localparam int WrCycles = 29 * 4 * ClkDiv;
  localparam int RdCycles = 39 * 4 * ClkDiv;
`ifdef I2C_MASTER_NACK_ABORT_EN
  localparam int NackCycles = 11 * 4 * ClkDiv;
`else
  localparam int NackCycles = WrCycles;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] data_wr = '0;
  logic [7:0] data_rd;
  logic       busy, ack_error, scl;
  wire        sda;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_master_ctrl #(.CLK_DIV(ClkDiv)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .rw         (rw),
    .slave_addr (slave_addr),
    .reg_addr   (reg_addr),
    .data_wr    (data_wr),
    .data_rd    (data_rd),
    .busy       (busy),
    .ack_error  (ack_error),
    .sda        (sda),
    .scl        (scl)
  );

  // ---------------- behavioural slave + bus monitor ----------------
  localparam int SIdle = 0, SRx = 1, SAck = 2, STx = 3, SMack = 4;

  logic       slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  logic [7:0] bus_log [$];
  int         starts = 0, stops = 0;
  int         s_state = SIdle, kind = 0, rx_cnt = 0, tx_cnt = 0;
  logic [7:0] rx_byte = '0, tx_byte = '0, ptr = '0;
  logic       rd_req = 1'b0, ack = 1'b0, master_ack_bit = 1'b0;
  logic       ps_scl = 1'b1, ps_sda = 1'b1;

  always @(scl or sda) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h20] = 8'hC3;
      mem_ready = 1'b1;
    end
    if (scl !== ps_scl) begin
      if (scl === 1'b1) begin
        if (s_state == SRx) begin
          rx_byte = {rx_byte[6:0], sda};
          rx_cnt++;
        end else if (s_state == SMack) begin
          master_ack_bit = sda;
        end
      end else begin
        case (s_state)
          SRx: if (rx_cnt == 8) begin
            bus_log.push_back(rx_byte);
            ack = 1'b1;
            if (kind == 0) begin
              ack    = (rx_byte[7:1] == 7'h68);
              rd_req = rx_byte[0];
            end else if (kind == 1) begin
              ptr = rx_byte;
            end else begin
              mem[ptr] = rx_byte;
              ptr++;
            end
            if (ack) begin
              slave_low = 1'b1;
              s_state   = SAck;
            end else begin
              s_state = SIdle;
            end
          end
          SAck: begin
            slave_low = 1'b0;
            if (kind == 0 && rd_req) begin
              tx_byte   = mem[ptr];
              slave_low = ~tx_byte[7];
              tx_cnt    = 1;
              s_state   = STx;
            end else begin
              kind    = (kind == 0) ? 1 : 2;
              rx_cnt  = 0;
              s_state = SRx;
            end
          end
          STx: begin
            if (tx_cnt < 8) begin
              slave_low = ~tx_byte[7-tx_cnt];
              tx_cnt++;
            end else begin
              slave_low = 1'b0;
              s_state   = SMack;
            end
          end
          SMack: s_state = SIdle;
          default: ;
        endcase
      end
    end else if (sda !== ps_sda && scl === 1'b1) begin
      // SDA edge while SCL high: START or STOP.
      slave_low = 1'b0;
      if (sda === 1'b0) begin
        starts++;
        s_state = SRx;
        kind    = 0;
        rx_cnt  = 0;
      end else begin
        stops++;
        s_state = SIdle;
      end
    end
    ps_scl = scl;
    ps_sda = sda;
  end

  // ---------------- transaction driver ----------------
  int log_base, st0, sp0, cyc;

  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] ra,
                         input logic [7:0] d, input int pulse_at, output int cycles);
    log_base = bus_log.size();
    st0 = starts;
    sp0 = stops;
    @(negedge clk);
    rw = r; slave_addr = a; reg_addr = ra; data_wr = d; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 2000) begin
      cycles++;
      enable = (pulse_at != 0 && cycles == pulse_at);
      if (enable) begin
        data_wr  = ~d;
        reg_addr = ~ra;
      end
      @(negedge clk);
    end
    enable = 1'b0;
    checks++;
    if (cycles >= 2000) begin
      errors++;
      $display("FAIL txn_timeout: busy still %b after %0d cycles, required to fall", busy, cycles);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_error); end
    checks++; if (data_rd !== 8'h00) begin errors++; $display("FAIL reset_data_rd: got %h want 00", data_rd); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want released(1)", sda); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] exp [3];
    exp = '{8'hD0, 8'h10, 8'h5A};
    run_txn(1'b0, 7'h68, 8'h10, 8'h5A, 0, cyc);
    checks++; if (cyc != WrCycles) begin errors++; $display("FAIL wr_busy_len: got %0d want %0d", cyc, WrCycles); end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL wr_ack_error: got %b want 0", ack_error); end
    checks++; if (bus_log.size() - log_base != 3) begin errors++; $display("FAIL wr_byte_count: got %0d want 3", bus_log.size() - log_base); end
    for (int i = 0; i < 3; i++) begin
      if (log_base + i < bus_log.size()) begin
        checks++;
        if (bus_log[log_base+i] !== exp[i]) begin
          errors++; $display("FAIL wr_byte%0d: got %h want %h", i, bus_log[log_base+i], exp[i]);
        end
      end
    end
    checks++; if (mem[8'h10] !== 8'h5A) begin errors++; $display("FAIL wr_reg10: got %h want 5a", mem[8'h10]); end
    checks++; if (starts - st0 != 1 || stops - sp0 != 1) begin
      errors++; $display("FAIL wr_start_stop: got %0d/%0d want 1/1", starts - st0, stops - sp0); end
  endtask

  task automatic test_read();
    logic [7:0] exp [3];
    exp = '{8'hD0, 8'h20, 8'hD1};
    run_txn(1'b1, 7'h68, 8'h20, 8'h00, 0, cyc);
    checks++; if (cyc != RdCycles) begin errors++; $display("FAIL rd_busy_len: got %0d want %0d", cyc, RdCycles); end
    checks++; if (data_rd !== 8'hC3) begin errors++; $display("FAIL rd_data: got %h want c3", data_rd); end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL rd_ack_error: got %b want 0", ack_error); end
    checks++; if (bus_log.size() - log_base != 3) begin errors++; $display("FAIL rd_byte_count: got %0d want 3", bus_log.size() - log_base); end
    for (int i = 0; i < 3; i++) begin
      if (log_base + i < bus_log.size()) begin
        checks++;
        if (bus_log[log_base+i] !== exp[i]) begin
          errors++; $display("FAIL rd_byte%0d: got %h want %h", i, bus_log[log_base+i], exp[i]);
        end
      end
    end
    checks++; if (master_ack_bit !== 1'b1) begin errors++; $display("FAIL rd_master_nack: got %b want 1", master_ack_bit); end
    checks++; if (starts - st0 != 2 || stops - sp0 != 1) begin
      errors++; $display("FAIL rd_start_stop: got %0d/%0d want 2/1", starts - st0, stops - sp0); end
  endtask

  task automatic test_nack();
    run_txn(1'b0, 7'h69, 8'h10, 8'hEE, 0, cyc);
    checks++; if (ack_error !== 1'b1) begin errors++; $display("FAIL nack_flag: got %b want 1", ack_error); end
    checks++; if (cyc != NackCycles) begin errors++; $display("FAIL nack_busy_len: got %0d want %0d", cyc, NackCycles); end
    checks++; if (data_rd !== 8'hC3) begin errors++; $display("FAIL nack_data_rd_held: got %h want c3", data_rd); end
    checks++; if (bus_log.size() - log_base != 1 || bus_log[bus_log.size()-1] !== 8'hD2) begin
      errors++; $display("FAIL nack_addr_byte: got %0d bytes last %h want 1 byte d2",
                         bus_log.size() - log_base, bus_log[bus_log.size()-1]); end
    checks++; if (mem[8'h10] !== 8'h5A) begin errors++; $display("FAIL nack_reg10: got %h want 5a", mem[8'h10]); end
    repeat (5) @(negedge clk);
    checks++; if (ack_error !== 1'b1) begin errors++; $display("FAIL nack_sticky: got %b want 1", ack_error); end
    run_txn(1'b0, 7'h68, 8'h10, 8'h11, 0, cyc);
    checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL nack_clear: got %b want 0", ack_error); end
    checks++; if (mem[8'h10] !== 8'h11) begin errors++; $display("FAIL nack_next_write: got %h want 11", mem[8'h10]); end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 7'h68, 8'h10, 8'h3C, 50, cyc);
    checks++; if (cyc != WrCycles) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", cyc, WrCycles); end
    checks++; if (mem[8'h10] !== 8'h3C) begin errors++; $display("FAIL b2b_reg10: got %h want 3c", mem[8'h10]); end
    checks++; if (bus_log.size() - log_base != 3) begin errors++; $display("FAIL b2b_byte_count: got %0d want 3", bus_log.size() - log_base); end
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b0 || starts - st0 != 1) begin
      errors++; $display("FAIL b2b_single_txn: busy %b starts %0d want 0/1", busy, starts - st0); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rw = 1'b0; slave_addr = 7'h68; reg_addr = 8'h10; data_wr = 8'h99; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (84) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL rstmid_scl: got %b want 1", scl); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda: got %b want released(1)", sda); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (mem[8'h10] !== 8'h3C) begin errors++; $display("FAIL rstmid_no_write: got %h want 3c", mem[8'h10]); end
    run_txn(1'b0, 7'h68, 8'h10, 8'h77, 0, cyc);
    checks++; if (cyc != WrCycles) begin errors++; $display("FAIL rstmid_busy_len: got %0d want %0d", cyc, WrCycles); end
    checks++; if (mem[8'h10] !== 8'h77) begin errors++; $display("FAIL rstmid_reg10: got %h want 77", mem[8'h10]); end
    checks++; if (ack_error !== 1'b0) begin errors++; $display("FAIL rstmid_ack_error: got %b want 0", ack_error); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
